// File: rtl/cxd2545_pkg.sv
// Shared constants and types for the CXD2545 command front end, SENS selector and servo model.
package cxd2545_pkg;

   localparam int CMD_MAX_BITS = 24;

   localparam logic [1:0] LEN_8  = 2'd1;
   localparam logic [1:0] LEN_16 = 2'd2;
   localparam logic [1:0] LEN_24 = 2'd3;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_SHIFT = 2'd1,
      RX_OVF   = 2'd2
   } rx_state_e;

   // Command group addresses as seen in frame[7:4].
   typedef enum logic [3:0] {
      GRP_FOCUS_CTRL = 4'h0,
      GRP_TRK_CTRL   = 4'h1,
      GRP_TRK_MODE   = 4'h2,
      GRP_SELECT     = 4'h3,
      GRP_AUTO_SEQ   = 4'h4,
      GRP_BLIND_BRK  = 4'h5,
      GRP_KICK_TIME  = 4'h6,
      GRP_SEQ_TRACK  = 4'h7,
      GRP_MODE_SPEC  = 4'h8,
      GRP_FUNC_SPEC  = 4'h9,
      GRP_AUDIO_CTRL = 4'hA,
      GRP_TRAV_CNT   = 4'hB,
      GRP_SPDL_COEF  = 4'hC,
      GRP_CLV_CTRL   = 4'hD,
      GRP_CLV_MODE   = 4'hE,
      GRP_RESERVED   = 4'hF
   } cmd_grp_e;

   function automatic logic [1:0] len_code(input logic [4:0] bits);
      case (bits)
         5'd8:    len_code = LEN_8;
         5'd16:   len_code = LEN_16;
         5'd24:   len_code = LEN_24;
         default: len_code = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/cxd2545_sync_edge.sv
// N-stage synchronizer with registered rise/fall detect; lvl_o is aligned with the edge strobes.
module cxd2545_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic sclk,
   input  logic rst_n,
   input  logic async_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q, rise_q, fall_q;

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         dly_q  <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~dly_q;
         fall_q <= ~sync_q[STAGES-1] & dly_q;
      end
   end

   assign lvl_o  = dly_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/cxd2545_cmd_rx.sv
// Oversampling MCU command receiver: frames bits on serial clk, validates on xlat fall, keeps a per-address bank.
module cxd2545_cmd_rx
   import cxd2545_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        sclk,
   input  logic        rst_n,
   input  logic        clk,
   input  logic        data,
   input  logic        xlat,
   output logic        cmd_valid,
   output logic [3:0]  cmd_addr,
   output logic [19:0] cmd_data,
   output logic [1:0]  cmd_len,
   output logic        frame_err,
   output logic [7:0]  cmd_cnt,
   input  logic [3:0]  rd_addr,
   output logic [19:0] rd_data
);

   localparam logic [4:0] MAX_BITS = 5'(CMD_MAX_BITS);
   localparam logic [4:0] SAT_BITS = 5'(CMD_MAX_BITS + 1);

   logic clk_lvl, clk_rise, clk_fall;
   logic data_lvl, data_rise, data_fall;
   logic xlat_lvl, xlat_rise, xlat_fall;
   logic unused_edges;

   cxd2545_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
      .sclk(sclk), .rst_n(rst_n), .async_i(clk),
      .lvl_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall));

   cxd2545_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
      .sclk(sclk), .rst_n(rst_n), .async_i(data),
      .lvl_o(data_lvl), .rise_o(data_rise), .fall_o(data_fall));

   // xlat idles high, so its chain resets high to avoid a spurious fall.
   cxd2545_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_xlat (
      .sclk(sclk), .rst_n(rst_n), .async_i(xlat),
      .lvl_o(xlat_lvl), .rise_o(xlat_rise), .fall_o(xlat_fall));

   assign unused_edges = ^{clk_lvl, clk_fall, data_rise, data_fall, xlat_rise};

   rx_state_e   state_q;
   logic [23:0] frame_q;
   logic [4:0]  bitcnt_q;
   logic        cmd_valid_q, frame_err_q;
   logic [3:0]  cmd_addr_q;
   logic [19:0] cmd_data_q;
   logic [1:0]  cmd_len_q;
   logic [7:0]  cmd_cnt_q;
   logic [19:0] bank_q [16];

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RX_IDLE;
         frame_q     <= '0;
         bitcnt_q    <= '0;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
         cmd_len_q   <= '0;
         cmd_cnt_q   <= '0;
         for (int i = 0; i < 16; i++) bank_q[i] <= '0;
      end else begin
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         // Bank commits during the strobe cycle, so a same-cycle read still sees the old entry.
         if (cmd_valid_q) bank_q[cmd_addr_q] <= cmd_data_q;

         if (xlat_fall) begin
            state_q  <= RX_IDLE;
            frame_q  <= '0;
            bitcnt_q <= '0;
            case (bitcnt_q)
               5'd8, 5'd16, 5'd24: begin
                  cmd_valid_q <= 1'b1;
                  cmd_addr_q  <= frame_q[7:4];
                  cmd_data_q  <= {frame_q[23:8], frame_q[3:0]};
                  cmd_len_q   <= len_code(bitcnt_q);
                  cmd_cnt_q   <= cmd_cnt_q + 8'd1;
               end
               5'd0:    ;
               default: frame_err_q <= 1'b1;
            endcase
         end else if (clk_rise && xlat_lvl) begin
            if (bitcnt_q < MAX_BITS) frame_q[bitcnt_q] <= data_lvl;
            if (bitcnt_q != SAT_BITS) bitcnt_q <= bitcnt_q + 5'd1;
            case (state_q)
               RX_IDLE:  state_q <= RX_SHIFT;
               RX_SHIFT: if (bitcnt_q == MAX_BITS) state_q <= RX_OVF;
               default:  state_q <= state_q;
            endcase
         end
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign frame_err = frame_err_q;
   assign cmd_addr  = cmd_addr_q;
   assign cmd_data  = cmd_data_q;
   assign cmd_len   = cmd_len_q;
   assign cmd_cnt   = cmd_cnt_q;
   assign rd_data   = bank_q[rd_addr];

endmodule

// File: tb/tb_cxd2545_cmd_rx.sv
// Directed bench for cxd2545_cmd_rx: MCU serial frames driven at 100 ns bit period against a 10 ns sclk.
module tb_cxd2545_cmd_rx;

   logic        sclk = 1'b0;
   logic        rst_n, clk, data, xlat;
   logic        cmd_valid, frame_err;
   logic [3:0]  cmd_addr, rd_addr;
   logic [19:0] cmd_data, rd_data;
   logic [1:0]  cmd_len;
   logic [7:0]  cmd_cnt;

   int tests = 0, fails = 0;
   int nv, ne, vlat, elat, tot_v = 0, tot_e = 0, v0, e0;
   logic [19:0] rd_at_valid;

   cxd2545_cmd_rx #(.SYNC_STAGES(2)) dut (
      .sclk(sclk), .rst_n(rst_n), .clk(clk), .data(data), .xlat(xlat),
      .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_len(cmd_len), .frame_err(frame_err), .cmd_cnt(cmd_cnt),
      .rd_addr(rd_addr), .rd_data(rd_data));

   always #5 sclk = ~sclk;

   always @(negedge sclk) begin
      if (cmd_valid) tot_v++;
      if (frame_err) tot_e++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         data = v[i];
         #50 clk = 1'b1;
         #50 clk = 1'b0;
      end
   endtask

   // Drop xlat (optionally with a coincident clk rise) and watch strobes for 12 sclk cycles.
   task automatic latch(input bit with_clk);
      nv = 0; ne = 0; vlat = 0; elat = 0; rd_at_valid = 'x;
      #50;
      @(negedge sclk);
      if (with_clk) clk = 1'b1;
      xlat = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge sclk);
         if (cmd_valid) begin
            nv++;
            if (vlat == 0) begin vlat = c; rd_at_valid = rd_data; end
         end
         if (frame_err) begin
            ne++;
            if (elat == 0) elat = c;
         end
      end
      clk  = 1'b0;
      xlat = 1'b1;
      repeat (6) @(negedge sclk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge sclk);
      rst_n = 1'b1;
      repeat (3) @(negedge sclk);
   endtask

   initial begin
      rst_n = 1'b0; clk = 1'b0; data = 1'b0; xlat = 1'b1; rd_addr = 4'h0;
      do_reset();
      chk("rst_valid", cmd_valid, 0);
      chk("rst_err",   frame_err, 0);
      chk("rst_addr",  cmd_addr, 0);
      chk("rst_data",  cmd_data, 0);
      chk("rst_len",   cmd_len, 0);
      chk("rst_cnt",   cmd_cnt, 0);
      chk("rst_bank0", rd_data, 0);

      // 8-bit frame 0x8A
      send_bits(32'h8A, 8);
      latch(0);
      chk("f8_nvalid", nv, 1);
      chk("f8_latency", vlat, 4);
      chk("f8_nerr", ne, 0);
      chk("f8_addr", cmd_addr, 4'h8);
      chk("f8_data", cmd_data, 20'h0000A);
      chk("f8_len",  cmd_len, 1);
      chk("f8_cnt",  cmd_cnt, 1);

      // 24-bit frame 0x12,0x34,0x56; read-during-write returns old bank value
      rd_addr = 4'h1;
      send_bits(32'h563412, 24);
      latch(0);
      chk("f24_nvalid", nv, 1);
      chk("f24_addr", cmd_addr, 4'h1);
      chk("f24_data", cmd_data, 20'h56342);
      chk("f24_len",  cmd_len, 3);
      chk("f24_cnt",  cmd_cnt, 2);
      chk("f24_rd_same_cycle", rd_at_valid, 20'h0);
      chk("f24_rd_after", rd_data, 20'h56342);

      // 5-bit frame rejected
      send_bits(32'h15, 5);
      latch(0);
      chk("f5_nerr", ne, 1);
      chk("f5_err_latency", elat, 4);
      chk("f5_nvalid", nv, 0);
      chk("f5_addr_hold", cmd_addr, 4'h1);
      chk("f5_data_hold", cmd_data, 20'h56342);
      chk("f5_cnt_hold", cmd_cnt, 2);
      rd_addr = 4'h8;
      #1 chk("f5_bank8", rd_data, 20'h0000A);
      rd_addr = 4'h1;
      #1 chk("f5_bank1", rd_data, 20'h56342);

      // Empty frame: silent
      latch(0);
      chk("f0_nvalid", nv, 0);
      chk("f0_nerr", ne, 0);

      // 25-bit overflow, then a good frame
      send_bits(32'h1FFFFFF, 25);
      latch(0);
      chk("f25_nerr", ne, 1);
      chk("f25_nvalid", nv, 0);
      chk("f25_cnt_hold", cmd_cnt, 2);
      send_bits(32'h5B, 8);
      latch(0);
      chk("post_ovf_nvalid", nv, 1);
      chk("post_ovf_addr", cmd_addr, 4'h5);
      chk("post_ovf_data", cmd_data, 20'h0000B);
      chk("post_ovf_cnt", cmd_cnt, 3);

      // 16-bit frame 0xA7,0x9E
      send_bits(32'h9EA7, 16);
      latch(0);
      chk("f16_addr", cmd_addr, 4'hA);
      chk("f16_data", cmd_data, 20'h009E7);
      chk("f16_len",  cmd_len, 2);
      chk("f16_cnt",  cmd_cnt, 4);

      // xlat fall coincides with a 9th clk rise: bit dropped
      send_bits(32'h3C, 8);
      data = 1'b1;
      latch(1);
      chk("coinc_nvalid", nv, 1);
      chk("coinc_nerr", ne, 0);
      chk("coinc_addr", cmd_addr, 4'h3);
      chk("coinc_data", cmd_data, 20'h0000C);
      chk("coinc_len",  cmd_len, 1);

      // 256 frames from zero: counter wraps
      do_reset();
      chk("rst2_cnt", cmd_cnt, 0);
      chk("rst2_bank1", rd_data, 0);
      for (int i = 0; i < 255; i++) begin
         send_bits(32'(i), 8);
         latch(0);
      end
      chk("wrap_255", cmd_cnt, 8'hFF);
      send_bits(32'hFF, 8);
      latch(0);
      chk("wrap_0", cmd_cnt, 8'h00);
      chk("wrap_last_addr", cmd_addr, 4'hF);

      // Reset mid-frame discards the partial frame
      send_bits(32'hABC, 12);
      v0 = tot_v; e0 = tot_e;
      do_reset();
      chk("midrst_no_valid", tot_v - v0, 0);
      chk("midrst_no_err", tot_e - e0, 0);
      chk("midrst_cnt", cmd_cnt, 0);
      send_bits(32'h47, 8);
      latch(0);
      chk("f47_nvalid", nv, 1);
      chk("f47_nerr", ne, 0);
      chk("f47_addr", cmd_addr, 4'h4);
      chk("f47_data", cmd_data, 20'h00007);
      chk("f47_cnt",  cmd_cnt, 1);
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         #1 chk($sformatf("f47_bank%0d", a), rd_data, (a == 4) ? 20'h7 : 20'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cxd2545_cmd_rx.md
# cxd2545_cmd_rx

Front-end command receiver for the CXD2545 emulation. It sits directly upstream of the SENS selector and shares the same MCU serial lines (`clk`, `data`, `xlat`). The block oversamples those lines on the system clock, assembles complete 8/16/24-bit command frames, and validates each frame when `xlat` falls. It then publishes every accepted command as a one-cycle strobe and keeps the last payload per address in a 16-entry register bank, which the servo/sens model stages read.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on `clk`/`data`/`xlat`; legal values 2..3.

Ports:
- `sclk`  in  1: system clock. Everything is sampled on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clk`  in  1: MCU serial clock (asynchronous). A bit is captured on its rising edge.
- `data`  in  1: MCU serial data, sent LSB first.
- `xlat`  in  1: MCU latch, idle high. Its falling edge ends a frame.
- `cmd_valid`  out  1: one-cycle strobe marking an accepted frame.
- `cmd_addr`  out  4: command address.
- `cmd_data`  out  20: command payload, zero-extended.
- `cmd_len`  out  2: 1, 2 or 3 bytes.
- `frame_err`  out  1: one-cycle strobe marking a rejected frame.
- `cmd_cnt`  out  8: count of accepted frames; wraps at 255 to 0.
- `rd_addr`  in  4: bank read address.
- `rd_data`  out  20: bank contents at `rd_addr`; combinational read.

## Operation
- Each of `clk`, `data` and `xlat` passes through a `SYNC_STAGES` flop synchronizer followed by an edge-detect flop. `data` is sampled from its synchronized copy in the same cycle as the `clk` rise is detected.
- Frame buffer: `frame[23:0]` plus a 5-bit `bitcnt`.
  - Received bit n is written to `frame[n]`.
  - `bitcnt` saturates at 25.
- FSM states:
  - IDLE: waiting for the first bit.
  - SHIFT: capturing bits.
  - OVF: `bitcnt` has reached 25.
  - Transitions: IDLE→SHIFT on the first `clk` rise while `xlat` is high. SHIFT→OVF when the 25th bit arrives. Any state→IDLE on an `xlat` fall.
- `clk` rises while synchronized `xlat` is low are ignored.
- If an `xlat` fall and a `clk` rise are detected in the same cycle, the bit is discarded and the frame ends.
- Actions on an `xlat` fall:
  - `bitcnt` of 8, 16 or 24 → accept. `cmd_addr` = `frame[7:4]`. `cmd_data` = {`frame[23:8]`, `frame[3:0]`}, with bytes that were not received set to 0. `cmd_len` = `bitcnt`/8. `bank[cmd_addr]` ← `cmd_data`. `cmd_cnt` increments.
  - `bitcnt` of 0 → no action: no strobe and no error.
  - Any other `bitcnt` value, including OVF → pulse `frame_err`. The bank, `cmd_cnt` and the `cmd_*` outputs are left unchanged.
  - In every case, `frame` and `bitcnt` clear.
- `cmd_addr`, `cmd_data` and `cmd_len` hold their values until the next accepted frame.

## Timing
- Reset values:
  - All outputs are 0, and all bank entries are 0.
  - The FSM enters IDLE.
  - Synchronizer flops reset high for `xlat` and low for `clk`/`data`, so reset release produces no false edges.
- Latency from the `xlat` pin fall to `cmd_valid` is `SYNC_STAGES`+2 `sclk` cycles. `frame_err` has the same latency.
- The bank write takes effect in the same cycle as `cmd_valid`. `rd_data` reflects the new value on the following cycle.
- Minimum MCU `clk` high and low times are each `SYNC_STAGES`+1 `sclk` periods. Faster clocks are unsupported; no detection is required.
- When a bank write and a read hit the same address in the same cycle, the read returns the old value.
- If `rst_n` is asserted mid-frame, the partial frame is discarded. No strobe and no error are produced.

## Structure
- Shared package `cxd2545_pkg`:
  - `CMD_MAX_BITS` = 24.
  - Length codes `LEN_8`, `LEN_16`, `LEN_24`.
  - FSM state typedef.
  - Address constants for the CXD2545 command groups (0x0–0xF), shared with the SENS selector and the servo model.
- One sub-module, `cxd2545_sync_edge`: an N-stage synchronizer plus rise/fall detect. It is instantiated three times.

## Test plan
- Send 8 bits of 0x8A LSB first, then pulse `xlat` → `cmd_valid` once; `cmd_addr`=0x8, `cmd_data`=0x0000A, `cmd_len`=1, `cmd_cnt`=1.
- Send 24 bits of bytes 0x12, 0x34, 0x56 → `cmd_addr`=0x1, `cmd_data`=0x56342, `cmd_len`=3. `rd_addr`=1 then reads 0x56342.
- Send 5 bits, then `xlat` → `frame_err` pulses once, no `cmd_valid`, bank unchanged. Send 25 bits → `frame_err`; a following valid 8-bit frame is accepted.
- Make the `xlat` fall coincide with the 9th `clk` rise after 8 bits of 0x3C → the 9th bit is dropped; accepted with `cmd_addr`=0x3, `cmd_data`=0xC.
- Send 256 valid frames → `cmd_cnt` wraps to 0. Assert `rst_n` low after 12 bits, release, then send 0x47 → only the 0x47 frame is reported, and the bank holds only that entry.
